alu_mem_sequencer: RTL
======================

Name: alu_mem_sequencer

Overview:
- Multi-cycle controller that executes one register-file command at a time through the 16x16 register memory and the 3-bit-opcode ALU.
- Per command: reads Src1/Src2, latches the ALU result, writes it back to Dest, then optionally triggers an LCD refresh.
- Replaces direct switch/KEY control of RegWrite and the write-data mux; sits between the board-level input logic and the memory/ALU/LCD instances.

Parameters:
- LCD_TIMEOUT, 24'd8_000_000: max cycles to wait for each LCD busy edge before flagging an error.
- CNT_W, 16: width of the executed-command counter.

Ports:
- clk  in  1  system clock (50 MHz).
- reset_n  in  1  asynchronous reset, active low.
- cmd_valid  in  1  command offered.
- cmd_ready  out  1  high only in IDLE.
- cmd_load  in  1  1 = write cmd_imm zero-extended; 0 = write ALU result.
- cmd_op  in  3  ALU opcode.
- cmd_dest  in  4  destination register.
- cmd_src1  in  4  operand A register.
- cmd_src2  in  4  operand B register.
- cmd_imm  in  8  immediate for load.
- mem_src1  out  4  memory read address 1.
- mem_src2  out  4  memory read address 2.
- mem_dest  out  4  memory write address.
- mem_wdata  out  16  memory write data.
- mem_we  out  1  memory write strobe, one cycle.
- alu_param  out  3  opcode to ALU.
- alu_s  in  17  combinational ALU result; bit 16 is carry.
- lcd_start  out  1  one-cycle LCD refresh request.
- lcd_busy  in  1  LCD controller busy.
- result  out  16  last written value.
- carry  out  1  alu_s[16] of the last ALU command; 0 after a load.
- done  out  1  one-cycle pulse at end of each command.
- lcd_err  out  1  sticky LCD timeout flag.
- cmd_count  out  CNT_W  completed commands, wraps.

Behaviour:
- Reset (async, reset_n=0): state=IDLE. All outputs 0, except cmd_ready=1 once reset releases.
- Reset mid-command aborts it. mem_we drops immediately, so no partial write occurs.
- States: IDLE, EXEC, WRITE, LCD_ACK, LCD_WAIT, DONE.
- IDLE: cmd_ready=1. On cmd_valid, latch all cmd_* fields and go to EXEC.
- EXEC (1 cycle): mem_src1/mem_src2/alu_param are driven from the latches. Register res_q = cmd_load ? {8'h00,imm} : alu_s[15:0]. Register carry_q = cmd_load ? 0 : alu_s[16]. Go to WRITE.
- mem_src1/mem_src2/alu_param hold their latched values in all non-IDLE states.
- WRITE (1 cycle): mem_we=1, mem_dest=latched dest, mem_wdata=res_q. Update result/carry outputs. Next state is LCD_ACK, or DONE when the LCD feature is off.
- LCD_ACK: lcd_start=1 on entry cycle only. Wait for lcd_busy=1, then go to LCD_WAIT.
- LCD_WAIT: wait for lcd_busy=0, then go to DONE.
- LCD timeouts: one timeout counter, cleared on each LCD state entry. At LCD_TIMEOUT cycles in either LCD state: set lcd_err and go to DONE.
- DONE (1 cycle): done=1, cmd_count+1, go to IDLE.
- Latency without LCD, accept edge to done: 3 cycles (EXEC, WRITE, DONE); next accept is 1 cycle after done.
- Dest equal to src1/src2: a read-before-write hazard cannot occur, because operands are sampled in EXEC and written in WRITE.
- cmd_valid outside IDLE is ignored; cmd_ready=0 there. The command is not lost, since the requester must hold it.
- lcd_err clears only on reset.
- cmd_count wraps from all-ones to 0.

Optional Feature:
- ALU_SEQ_LCD_SYNC_EN defined: LCD_ACK/LCD_WAIT exist, lcd_start is pulsed, the timeout counter is present.
- Not defined: WRITE goes straight to DONE, lcd_start and lcd_err are tied 0, and lcd_busy is unused.

Decomposition:
- Package alu_seq_pkg holds:
  - the state enum (3-bit encoding);
  - the ALU opcode constants (3-bit);
  - the register address width (4);
  - the data width (16).
- One sub-module, alu_seq_lcd_handshake, holds the LCD_ACK/LCD_WAIT handshake plus timeout counter, with ports start_req, lcd_busy, lcd_start, ack_done, timeout. The top FSM waits on its ack_done.

Test Plan:
- Reset: hold reset_n=0 mid-EXEC with valid high -> all outputs 0, no mem_we. After release, cmd_ready=1 next cycle.
- Load: cmd_load=1, imm=8'hA5, dest=3 -> mem_we one cycle with mem_dest=3, mem_wdata=16'h00A5. result=16'h00A5, carry=0, done 3 cycles after accept (LCD off), cmd_count=1.
- ALU op with carry: model alu_s=17'h1_0001, op=add, src1=1, src2=2, dest=1 -> mem_wdata=16'h0001, carry=1. Addresses stay stable from EXEC through DONE.
- Back-to-back: cmd_valid held high for 3 commands -> exactly 3 accepts, 3 done pulses, cmd_count=3, cmd_ready low between accepts.
- LCD handshake (feature on): lcd_busy rises 2 cycles after lcd_start and falls 10 cycles later -> done exactly 1 cycle after the fall, lcd_err=0.
- LCD timeout (feature on, LCD_TIMEOUT=16): lcd_busy stuck 0 -> lcd_err=1 after 16 cycles in LCD_ACK, then done, then return to IDLE.

Source files
------------

// File: rtl/alu_seq_pkg.sv
// alu_seq_pkg: widths, state codes, ALU opcodes and the latched
// command bundle shared by the alu_mem_sequencer slice.
package alu_seq_pkg;

  localparam int AW = 4;
  localparam int DW = 16;

  typedef logic [2:0] state_t;

  localparam state_t S_IDLE     = 3'd0;
  localparam state_t S_EXEC     = 3'd1;
  localparam state_t S_WRITE    = 3'd2;
  localparam state_t S_LCD_ACK  = 3'd3;
  localparam state_t S_LCD_WAIT = 3'd4;
  localparam state_t S_DONE     = 3'd5;

  localparam logic [2:0] OP_ADD = 3'd0;
  localparam logic [2:0] OP_SUB = 3'd1;
  localparam logic [2:0] OP_AND = 3'd2;
  localparam logic [2:0] OP_OR  = 3'd3;
  localparam logic [2:0] OP_XOR = 3'd4;
  localparam logic [2:0] OP_NOT = 3'd5;
  localparam logic [2:0] OP_SHL = 3'd6;
  localparam logic [2:0] OP_SHR = 3'd7;

  typedef logic [AW-1:0] addr_t;
  typedef logic [DW-1:0] data_t;

  typedef struct packed {
    logic       load;
    logic [2:0] op;
    addr_t      dest;
    addr_t      src1;
    addr_t      src2;
    logic [7:0] imm;
  } cmd_t;

  function automatic data_t zext_imm(input logic [7:0] imm);
    return {8'h00, imm};
  endfunction

endpackage

// File: rtl/alu_seq_lcd_handshake.sv
// alu_seq_lcd_handshake: start pulse, busy-rise then busy-fall wait,
// with one timeout counter restarted on entry to each phase.
module alu_seq_lcd_handshake
  import alu_seq_pkg::*;
#(
  parameter logic [23:0] LCD_TIMEOUT = 24'd8_000_000
) (
  input  logic clk,
  input  logic reset_n,
  input  logic start_req,
  input  logic lcd_busy,
  output logic lcd_start,
  output logic ack_done,
  output logic timeout
);

  state_t      ph;
  logic [23:0] cnt;
  logic        in_ack;
  logic        in_wait;
  logic        go_wait;
  logic        go_done;
  logic        stalled;
  logic        at_lim;
  logic        hold;

  assign in_ack  = ph == S_LCD_ACK;
  assign in_wait = ph == S_LCD_WAIT;
  assign go_wait = in_ack && lcd_busy;
  assign go_done = in_wait && !lcd_busy;
  assign at_lim  = cnt == LCD_TIMEOUT - 24'd1;

  // a phase only times out on a cycle where it makes no progress
  assign stalled  = (in_ack && !lcd_busy) ||
                    (in_wait && lcd_busy);
  assign timeout  = stalled && at_lim;
  assign ack_done = go_done || timeout;
  assign hold     = stalled && !at_lim;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ph        <= S_IDLE;
      cnt       <= '0;
      lcd_start <= 1'b0;
    end else begin
      lcd_start <= start_req;
      unique case (1'b1)
        start_req: begin
          ph  <= S_LCD_ACK;
          cnt <= '0;
        end
        go_wait: begin
          ph  <= S_LCD_WAIT;
          cnt <= '0;
        end
        ack_done: begin
          ph  <= S_IDLE;
          cnt <= '0;
        end
        hold: cnt <= cnt + 24'd1;
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/alu_mem_sequencer.sv
// alu_mem_sequencer: one register-file command at a time through the
// memory and ALU. Define ALU_SEQ_LCD_SYNC_EN for the LCD refresh handshake.
module alu_mem_sequencer
  import alu_seq_pkg::*;
#(
  parameter logic [23:0] LCD_TIMEOUT = 24'd8_000_000,
  parameter int          CNT_W       = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic             cmd_load,
  input  logic [2:0]       cmd_op,
  input  logic [3:0]       cmd_dest,
  input  logic [3:0]       cmd_src1,
  input  logic [3:0]       cmd_src2,
  input  logic [7:0]       cmd_imm,
  output logic [3:0]       mem_src1,
  output logic [3:0]       mem_src2,
  output logic [3:0]       mem_dest,
  output logic [15:0]      mem_wdata,
  output logic             mem_we,
  output logic [2:0]       alu_param,
  input  logic [16:0]      alu_s,
  output logic             lcd_start,
  input  logic             lcd_busy,
  output logic [15:0]      result,
  output logic             carry,
  output logic             done,
  output logic             lcd_err,
  output logic [CNT_W-1:0] cmd_count
);

  state_t state;
  state_t nxt;
  state_t after_write;
  cmd_t   cmd_q;
  data_t  res_q;
  logic   cry_q;
  logic   live_q;
  logic   accept;
  logic   ack_done;
  logic   timeout;

  // ready is held off for the first cycle after reset release
  assign cmd_ready = live_q && state == S_IDLE;
  assign accept    = cmd_valid && cmd_ready;

  assign mem_src1  = cmd_q.src1;
  assign mem_src2  = cmd_q.src2;
  assign alu_param = cmd_q.op;
  assign mem_dest  = cmd_q.dest;
  assign mem_wdata = res_q;
  assign mem_we    = state == S_WRITE;
  assign done      = state == S_DONE;

`ifdef ALU_SEQ_LCD_SYNC_EN
  assign after_write = S_LCD_ACK;

  alu_seq_lcd_handshake #(
    .LCD_TIMEOUT(LCD_TIMEOUT)
  ) u_lcd (
    .clk      (clk),
    .reset_n  (reset_n),
    .start_req(mem_we),
    .lcd_busy (lcd_busy),
    .lcd_start(lcd_start),
    .ack_done (ack_done),
    .timeout  (timeout)
  );
`else
  logic unused_lcd;

  assign after_write = S_DONE;
  assign lcd_start   = 1'b0;
  assign ack_done    = 1'b0;
  assign timeout     = 1'b0;
  assign unused_lcd  = ^{lcd_busy, LCD_TIMEOUT};
`endif

  always_comb begin
    nxt = state;
    unique case (state)
      S_IDLE:    if (accept) nxt = S_EXEC;
      S_EXEC:    nxt = S_WRITE;
      S_WRITE:   nxt = after_write;
      S_LCD_ACK: if (ack_done) nxt = S_DONE;
      S_DONE:    nxt = S_IDLE;
      default:   nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= S_IDLE;
      live_q    <= 1'b0;
      cmd_q     <= '0;
      res_q     <= '0;
      cry_q     <= 1'b0;
      result    <= '0;
      carry     <= 1'b0;
      cmd_count <= '0;
      lcd_err   <= 1'b0;
    end else begin
      state  <= nxt;
      live_q <= 1'b1;
      if (accept) begin
        cmd_q <= '{load: cmd_load, op: cmd_op,
                   dest: cmd_dest, src1: cmd_src1,
                   src2: cmd_src2, imm: cmd_imm};
      end
      // operands are sampled here, so dest==src cannot race the write
      if (state == S_EXEC) begin
        res_q <= cmd_q.load ? zext_imm(cmd_q.imm)
                            : alu_s[DW-1:0];
        cry_q <= !cmd_q.load && alu_s[DW];
      end
      if (mem_we) begin
        result <= res_q;
        carry  <= cry_q;
      end
      if (done)    cmd_count <= cmd_count + 1'b1;
      if (timeout) lcd_err   <= 1'b1;
    end
  end

endmodule
